// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command initiator: state encoding and
// default parameter values.
package alu_cmd_pkg;

  localparam int NB_DATA_DEF        = 8;
  localparam int NB_OP_DEF          = 6;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_OP  = 3'd1,
    SEND_A   = 3'd2,
    SEND_B   = 3'd3,
    WAIT_RES = 3'd4
  } state_t;

endpackage

// File: rtl/alu_cmd_master.sv
// Command initiator: pushes opcode, A, B into the outgoing FIFO, then pops one
// result byte. Optional result-wait timeout enabled by ALU_CMD_MASTER_TIMEOUT_EN.
module alu_cmd_master
  import alu_cmd_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OP-1:0]   i_op,
  input  logic [NB_DATA-1:0] i_data_a,
  input  logic [NB_DATA-1:0] i_data_b,
  output logic               o_busy,
  input  logic               i_tx_full,
  output logic               o_tx_write,
  output logic [NB_DATA-1:0] o_tx_writedata,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_readdata,
  output logic               o_rx_read,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout
);

  if (NB_OP > NB_DATA || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("alu_cmd_master: need NB_OP <= NB_DATA and TIMEOUT_CYCLES >= 1");
  end

  state_t             state;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;

  // Strobes are suppressed while reset is held so no FIFO side effect leaks out.
  assign o_busy = (state != IDLE) && !i_reset;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    o_tx_write     = 1'b0;
    o_tx_writedata = '0;
    o_rx_read      = 1'b0;
    case (state)
      SEND_OP: begin
        o_tx_write     = !i_tx_full && !i_reset;
        o_tx_writedata = NB_DATA'(op_q);
      end
      SEND_A: begin
        o_tx_write     = !i_tx_full && !i_reset;
        o_tx_writedata = a_q;
      end
      SEND_B: begin
        o_tx_write     = !i_tx_full && !i_reset;
        o_tx_writedata = b_q;
      end
      WAIT_RES: o_rx_read = !i_rx_empty && !i_reset;
      default: ;
    endcase
  end

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= IDLE;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
      wait_cnt       <= '0;
      o_timeout      <= 1'b0;
`endif
    end else begin
      o_result_valid <= 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
      o_timeout      <= 1'b0;
`endif
      case (state)
        IDLE: if (i_start) begin
          op_q  <= i_op;
          a_q   <= i_data_a;
          b_q   <= i_data_b;
          state <= SEND_OP;
        end
        SEND_OP: if (!i_tx_full) state <= SEND_A;
        SEND_A:  if (!i_tx_full) state <= SEND_B;
        SEND_B: if (!i_tx_full) begin
          state <= WAIT_RES;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT_RES: begin
          if (!i_rx_empty) begin
            o_result       <= i_rx_readdata;
            o_result_valid <= 1'b1;
            state          <= IDLE;
          end
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
          else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master: table of per-cycle vectors plus hand
// sequences for reset mid-command and result-wait timeout.
module tb_alu_cmd_master;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [5:0] i_op;
  logic [7:0] i_data_a, i_data_b;
  logic       o_busy;
  logic       i_tx_full;
  logic       o_tx_write;
  logic [7:0] o_tx_writedata;
  logic       i_rx_empty;
  logic [7:0] i_rx_readdata;
  logic       o_rx_read;
  logic [7:0] o_result;
  logic       o_result_valid;
  logic       o_timeout;

  int n_applied = 0;
  int n_miss    = 0;

  always #5 clk = ~clk;

  alu_cmd_master #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(8)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_op           (i_op),
    .i_data_a       (i_data_a),
    .i_data_b       (i_data_b),
    .o_busy         (o_busy),
    .i_tx_full      (i_tx_full),
    .o_tx_write     (o_tx_write),
    .o_tx_writedata (o_tx_writedata),
    .i_rx_empty     (i_rx_empty),
    .i_rx_readdata  (i_rx_readdata),
    .o_rx_read      (o_rx_read),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .o_timeout      (o_timeout)
  );

  typedef struct {
    logic       start;
    logic [5:0] op;
    logic [7:0] a, b;
    logic       full, empty;
    logic [7:0] rxd;
    logic       busy, txw;
    logic [7:0] txd;
    logic       rxr, valid;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic start, input logic [5:0] op, input logic [7:0] a, b,
                     input logic full, empty, input logic [7:0] rxd,
                     input logic busy, txw, input logic [7:0] txd,
                     input logic rxr, valid, input logic [7:0] res);
    vec_t v;
    v.start = start; v.op = op; v.a = a; v.b = b; v.full = full; v.empty = empty;
    v.rxd = rxd; v.busy = busy; v.txw = txw; v.txd = txd; v.rxr = rxr;
    v.valid = valid; v.res = res;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic start, input logic [5:0] op, input logic [7:0] a, b);
    i_start = start; i_op = op; i_data_a = a; i_data_b = b;
  endtask

  task automatic chk_tx(input string tag, input logic busy, txw, input logic [7:0] txd);
    check({tag, " busy"}, 8'(o_busy), 8'(busy));
    check({tag, " tx_write"}, 8'(o_tx_write), 8'(txw));
    check({tag, " tx_data"}, o_tx_writedata, txd);
  endtask

  initial begin
    i_reset = 1'b1; i_tx_full = 1'b0; i_rx_empty = 1'b1; i_rx_readdata = 8'h00;
    drive(1'b0, 6'h00, 8'h00, 8'h00);
    step(); step();

    chk_tx("reset", 1'b0, 1'b0, 8'h00);
    check("reset rx_read", 8'(o_rx_read), 8'h00);
    check("reset result", o_result, 8'h00);
    check("reset valid", 8'(o_result_valid), 8'h00);
    check("reset timeout", 8'(o_timeout), 8'h00);
    i_reset = 1'b0;
    step();

    // st  op     a      b      full  empty rxd     busy txw  txd    rxr  vld  res
    // basic command, result present from cycle 6
    add(1, 6'h20, 8'h05, 8'h03, 0, 1, 8'h00,   0, 0, 8'h00, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h20, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h05, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h03, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 0, 8'h00, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 0, 8'h00, 0, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h08,   1, 0, 8'h00, 1, 0, 8'h00);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 1, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 0, 8'h08);
    // backpressure on cycles 2-5, previous result held
    add(1, 6'h11, 8'hA1, 8'hB2, 0, 1, 8'h00,   0, 0, 8'h00, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h11, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 1, 1, 8'h00,   1, 0, 8'hA1, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 1, 1, 8'h00,   1, 0, 8'hA1, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 1, 1, 8'h00,   1, 0, 8'hA1, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 1, 1, 8'h00,   1, 0, 8'hA1, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'hA1, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'hB2, 0, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h53,   1, 0, 8'h00, 1, 0, 8'h08);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 1, 8'h53);
    // start pulses in SEND_A and WAIT_RES are ignored
    add(1, 6'h0C, 8'h10, 8'h20, 0, 1, 8'h00,   0, 0, 8'h00, 0, 0, 8'h53);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h0C, 0, 0, 8'h53);
    add(1, 6'h3F, 8'hFF, 8'hEE, 0, 1, 8'h00,   1, 1, 8'h10, 0, 0, 8'h53);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   1, 1, 8'h20, 0, 0, 8'h53);
    add(1, 6'h3F, 8'hFF, 8'hEE, 0, 1, 8'h00,   1, 0, 8'h00, 0, 0, 8'h53);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h2C,   1, 0, 8'h00, 1, 0, 8'h53);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 1, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 0, 8'h2C);
    // stale byte waiting in the incoming FIFO while idle
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h55,   0, 0, 8'h00, 0, 0, 8'h2C);
    add(1, 6'h01, 8'h02, 8'h03, 0, 0, 8'h55,   0, 0, 8'h00, 0, 0, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h55,   1, 1, 8'h01, 0, 0, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h55,   1, 1, 8'h02, 0, 0, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h55,   1, 1, 8'h03, 0, 0, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 0, 8'h55,   1, 0, 8'h00, 1, 0, 8'h2C);
    add(0, 6'h00, 8'h00, 8'h00, 0, 1, 8'h00,   0, 0, 8'h00, 0, 1, 8'h55);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].op, vecs[i].a, vecs[i].b);
      i_tx_full = vecs[i].full; i_rx_empty = vecs[i].empty; i_rx_readdata = vecs[i].rxd;
      #1;
      chk_tx($sformatf("v%0d", i), vecs[i].busy, vecs[i].txw, vecs[i].txd);
      check($sformatf("v%0d rx_read", i), 8'(o_rx_read), 8'(vecs[i].rxr));
      check($sformatf("v%0d valid", i), 8'(o_result_valid), 8'(vecs[i].valid));
      check($sformatf("v%0d result", i), o_result, vecs[i].res);
      check($sformatf("v%0d timeout", i), 8'(o_timeout), 8'h00);
      step();
    end
    i_rx_empty = 1'b1; i_rx_readdata = 8'h00;

    // reset while B is being sent: no write that cycle, nothing resumes
    drive(1'b1, 6'h2A, 8'h77, 8'h66);
    step();
    drive(1'b0, 6'h00, 8'h00, 8'h00);
    step(); step();
    chk_tx("pre_rst", 1'b1, 1'b1, 8'h66);
    i_reset = 1'b1;
    #1;
    check("rst_cycle tx_write", 8'(o_tx_write), 8'h00);
    step();
    chk_tx("post_rst", 1'b0, 1'b0, 8'h00);
    check("post_rst result", o_result, 8'h00);
    check("post_rst valid", 8'(o_result_valid), 8'h00);
    drive(1'b1, 6'h3F, 8'hFF, 8'hFF);
    step();
    chk_tx("rst_start", 1'b0, 1'b0, 8'h00);
    i_reset = 1'b0;
    drive(1'b0, 6'h00, 8'h00, 8'h00);
    step();
    chk_tx("idle_after_rst", 1'b0, 1'b0, 8'h00);
    drive(1'b1, 6'h05, 8'h09, 8'h0A);
    step();
    drive(1'b0, 6'h00, 8'h00, 8'h00);
    chk_tx("fresh op", 1'b1, 1'b1, 8'h05);
    step();
    chk_tx("fresh a", 1'b1, 1'b1, 8'h09);
    step();
    chk_tx("fresh b", 1'b1, 1'b1, 8'h0A);
    step();
    i_rx_empty = 1'b0; i_rx_readdata = 8'h13;
    #1;
    check("fresh rx_read", 8'(o_rx_read), 8'h01);
    step();
    i_rx_empty = 1'b1; i_rx_readdata = 8'h00;
    check("fresh valid", 8'(o_result_valid), 8'h01);
    check("fresh result", o_result, 8'h13);
    check("fresh busy", 8'(o_busy), 8'h00);

    // no result ever arrives
    drive(1'b1, 6'h07, 8'h01, 8'h02);
    step();
    drive(1'b0, 6'h00, 8'h00, 8'h00);
    step(); step(); step();
    chk_tx("wait_entry", 1'b1, 1'b0, 8'h00);
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("to k%0d timeout", k), 8'(o_timeout), 8'(k == 8));
      check($sformatf("to k%0d busy", k), 8'(o_busy), 8'(k < 8));
      check($sformatf("to k%0d result", k), o_result, 8'h13);
      check($sformatf("to k%0d valid", k), 8'(o_result_valid), 8'h00);
    end
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k % 5 == 0) begin
        check($sformatf("wait k%0d busy", k), 8'(o_busy), 8'h01);
        check($sformatf("wait k%0d timeout", k), 8'(o_timeout), 8'h00);
      end
    end
    i_rx_empty = 1'b0; i_rx_readdata = 8'h99;
    #1;
    check("late rx_read", 8'(o_rx_read), 8'h01);
    step();
    i_rx_empty = 1'b1;
    check("late valid", 8'(o_result_valid), 8'h01);
    check("late result", o_result, 8'h99);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 Parameter NB_DATA, default 8: byte width of the FIFO data paths, operands and result.
REQ-002 Parameter NB_OP, default 6: opcode width; NB_OP SHALL be at most NB_DATA.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000: result wait limit, used only under REQ-024.
REQ-004 i_clk  in  1  single clock; every register updates on its rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  request; sampled only in IDLE.
REQ-007 i_op  in  NB_OP  opcode to send.
REQ-008 i_data_a / i_data_b  in  NB_DATA  operands A and B.
REQ-009 o_busy  out  1  high whenever state is not IDLE.
REQ-010 i_tx_full  in  1  outgoing FIFO full.
REQ-011 o_tx_write / o_tx_writedata  out  1 / NB_DATA  push strobe and byte for the outgoing FIFO.
REQ-012 i_rx_empty / i_rx_readdata  in  1 / NB_DATA  incoming FIFO empty flag and head byte (first-word-fall-through).
REQ-013 o_rx_read  out  1  pop strobe for the incoming FIFO.
REQ-014 o_result / o_result_valid / o_timeout  out  NB_DATA / 1 / 1  last result, 1-cycle result pulse, 1-cycle timeout pulse.

Function
REQ-015 The block SHALL implement the command initiator for the opcode/A/B -> result byte protocol: it sends opcode, then A, then B, then pops exactly one result byte.
REQ-016 States SHALL be IDLE, SEND_OP, SEND_A, SEND_B and WAIT_RES.
REQ-017 In IDLE with i_start=1, the block SHALL latch i_op, i_data_a and i_data_b and enter SEND_OP next cycle; i_start outside IDLE SHALL be ignored.
REQ-018 In SEND_OP, SEND_A and SEND_B, o_tx_write SHALL equal ~i_tx_full (combinational), and the state SHALL advance only in cycles where the write occurs.
REQ-019 o_tx_writedata SHALL be:
- SEND_OP: latched opcode zero-extended to NB_DATA.
- SEND_A / SEND_B: latched A / latched B.
- All other states: 0.
REQ-020 In WAIT_RES, o_rx_read SHALL equal ~i_rx_empty (combinational); on the pop cycle, i_rx_readdata SHALL be registered into o_result, o_result_valid SHALL pulse the following cycle, and the state SHALL return to IDLE.
REQ-021 o_rx_read SHALL be 0 outside WAIT_RES; bytes present in the incoming FIFO while IDLE SHALL NOT be consumed.
REQ-022 Latency with no backpressure: i_start at cycle 0 -> writes at cycles 1, 2 and 3 -> WAIT_RES from cycle 4; a result pop at cycle N gives o_result_valid and o_busy=0 at cycle N+1.
REQ-023 o_result SHALL hold its value until the next successful pop.

Reset
REQ-025 i_reset=1 SHALL force, at the next edge and from any state including mid-command:
- state = IDLE.
- o_result = 0, latched operands = 0, timeout counter = 0.
- o_result_valid = 0, o_timeout = 0.
REQ-026 During and after reset, the following SHALL be 0 until a new i_start: o_tx_write, o_rx_read, o_busy.
REQ-027 A partially sent command SHALL NOT be resumed after reset.

Configuration
REQ-024 Macro ALU_CMD_MASTER_TIMEOUT_EN:
- Defined: a 16-bit counter SHALL clear on entry to WAIT_RES and increment each WAIT_RES cycle with i_rx_empty=1.
- Defined: when the count reaches TIMEOUT_CYCLES-1 while still empty, the block SHALL return to IDLE, pulse o_timeout for one cycle and leave o_result unchanged.
- Undefined: o_timeout SHALL be tied to 0, no counter SHALL exist, and WAIT_RES SHALL wait indefinitely.

Structure
REQ-028 Package alu_cmd_pkg SHALL hold:
- The state encoding constants.
- The default NB_DATA, NB_OP and TIMEOUT_CYCLES values.
REQ-029 The block SHALL be a single module with no sub-modules; the FIFOs are external.

Verification
REQ-030 Basic command: i_start with op=0x20, A=0x05, B=0x03, FIFO not full; result 0x08 present from cycle 6 -> writes 0x20, 0x05, 0x03 at cycles 1-3; o_rx_read at cycle 6; o_result=0x08 and o_result_valid at cycle 7.
REQ-031 Backpressure: i_tx_full=1 for cycles 2-5 -> A written at cycle 6, B at cycle 7, no duplicate or dropped byte.
REQ-032 Ignored start: i_start pulsed in SEND_A and in WAIT_RES with different operands -> original bytes sent; only one command issued.
REQ-033 Reset mid-operation: i_reset in SEND_B -> next cycle IDLE, o_busy=0, no further write; a fresh command then completes normally.
REQ-034 Timeout (macro defined, TIMEOUT_CYCLES=8): no result after B -> o_timeout pulses 8 cycles after WAIT_RES entry, IDLE follows, o_result unchanged; with macro undefined -> o_busy stays 1.
REQ-035 Stale data: incoming FIFO holds 0x55 while IDLE -> no o_rx_read until WAIT_RES, then 0x55 is popped as the result.
